// File: rtl/complex_dp_row_scheduler.sv
// Row sequencer for the complex dot-product engine: fetches n_chunks packages per row,
// strobes each into the engine, waits for its sticky finish and returns one result per row.
// Optional watchdog on the engine finish: define DP_SCHED_TIMEOUT_EN.
module complex_dp_row_scheduler #(
  parameter int unsigned ELEM_W  = 64,
  parameter int unsigned NU      = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [7:0]           i_n_rows,
  input  logic [7:0]           i_n_chunks,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_mat_rd_en,
  output logic [ADDR_W-1:0]    o_mat_addr,
  input  logic [ELEM_W*NU-1:0] i_mat_rdata,
  output logic                 o_vec_rd_en,
  output logic [ADDR_W-1:0]    o_vec_addr,
  input  logic [ELEM_W*NU-1:0] i_vec_rdata,
  output logic                 o_eng_reset,
  output logic                 o_eng_read_now,
  output logic [ELEM_W*NU-1:0] o_eng_first_row,
  output logic [ELEM_W*NU-1:0] o_eng_second_row,
  output logic [31:0]          o_eng_total,
  input  logic                 i_eng_finish,
  input  logic [ELEM_W-1:0]    i_eng_result,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [7:0]           o_res_row,
  output logic [ELEM_W-1:0]    o_res_data,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    StIdle, StRowRst, StFetch, StLoad, StIssue, StHold, StWait, StOut
  } state_e;

  state_e                r_state, w_state_next;
  logic [7:0]            r_rows, r_chunks, r_row, r_chunk;
  logic [ADDR_W-1:0]     r_pkg;
  logic [ELEM_W*NU-1:0]  r_first, r_second;
  logic [31:0]           r_total;
  logic [ELEM_W-1:0]     r_res_data;
  logic                  r_done;
  logic                  w_start_ok, w_last_chunk, w_last_row, w_timeout;

  assign w_start_ok   = i_start && (i_n_rows != 8'd0) && (i_n_chunks != 8'd0);
  assign w_last_chunk = (r_chunk == r_chunks - 8'd1);
  assign w_last_row   = (r_row == r_rows - 8'd1);

`ifdef DP_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TmoW-1:0] r_tmo;
  logic            r_err;

  assign w_timeout = (r_state == StWait) && !i_eng_finish && (r_tmo == TmoW'(TIMEOUT - 1));
  assign o_err     = r_err;

  // Count cycles spent in WAIT; error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (r_state == StWait) ? r_tmo + TmoW'(1) : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
  assign o_err            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_state_next   = r_state;
    o_mat_rd_en    = 1'b0;
    o_vec_rd_en    = 1'b0;
    o_eng_read_now = 1'b0;
    o_res_valid    = 1'b0;
    o_eng_reset    = reset;
    unique case (r_state)
      StIdle:   if (w_start_ok) w_state_next = StRowRst;
      StRowRst: begin
        o_eng_reset  = 1'b1;  // engine finish is sticky, so clear it per row
        w_state_next = StFetch;
      end
      StFetch: begin
        o_mat_rd_en  = 1'b1;
        o_vec_rd_en  = 1'b1;
        w_state_next = StLoad;
      end
      StLoad:   w_state_next = StIssue;
      StIssue: begin
        o_eng_read_now = 1'b1;
        w_state_next   = StHold;
      end
      StHold:   w_state_next = w_last_chunk ? StWait : StFetch;
      StWait:   if (i_eng_finish || w_timeout) w_state_next = StOut;
      StOut: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_state_next = w_last_row ? StIdle : StRowRst;
      end
      default:  w_state_next = StIdle;
    endcase
  end

  // Job registers, counters, engine operand latches and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows     <= '0;
      r_chunks   <= '0;
      r_row      <= '0;
      r_chunk    <= '0;
      r_pkg      <= '0;
      r_first    <= '0;
      r_second   <= '0;
      r_total    <= '0;
      r_res_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            r_rows   <= i_n_rows;
            r_chunks <= i_n_chunks;
            r_total  <= 32'(i_n_chunks) * 32'(NU);
            r_row    <= '0;
            r_pkg    <= '0;
          end else if (i_start) begin
            r_done <= 1'b1;  // empty job completes immediately
          end
        end
        StRowRst: r_chunk <= '0;
        StLoad: begin
          r_first  <= i_mat_rdata;
          r_second <= i_vec_rdata;
        end
        StHold: begin
          r_pkg <= r_pkg + ADDR_W'(1);
          if (!w_last_chunk) r_chunk <= r_chunk + 8'd1;
        end
        StWait: begin
          if (i_eng_finish)   r_res_data <= i_eng_result;
          else if (w_timeout) r_res_data <= '0;
        end
        StOut: begin
          if (i_res_ready) begin
            if (w_last_row) r_done <= 1'b1;
            else            r_row  <= r_row + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy           = (r_state != StIdle);
  assign o_done           = r_done;
  assign o_mat_addr       = r_pkg;
  assign o_vec_addr       = ADDR_W'(r_chunk);
  assign o_eng_first_row  = r_first;
  assign o_eng_second_row = r_second;
  assign o_eng_total      = r_total;
  assign o_res_row        = r_row;
  assign o_res_data       = r_res_data;

endmodule

// File: tb/tb_complex_dp_row_scheduler.sv
// Scoreboard bench for complex_dp_row_scheduler: memory and engine models, randomized jobs,
// expected row results computed directly from memory contents.
module tb_complex_dp_row_scheduler;

  localparam int unsigned ELEM_W = 64;
  localparam int unsigned NU     = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PW     = ELEM_W * NU;
`ifdef DP_SCHED_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 1023;
`endif

  logic              clk, reset, start, busy, done;
  logic [7:0]        n_rows, n_chunks, res_row;
  logic              mat_rd_en, vec_rd_en, eng_reset, eng_read_now, eng_finish;
  logic [ADDR_W-1:0] mat_addr, vec_addr;
  logic [PW-1:0]     mat_rdata, vec_rdata, eng_first_row, eng_second_row;
  logic [31:0]       eng_total;
  logic [63:0]       eng_result, res_data;
  logic              res_valid, res_ready, err;

  int checks = 0;
  int failures = 0;

  complex_dp_row_scheduler #(
    .ELEM_W (ELEM_W),
    .NU     (NU),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .i_n_rows        (n_rows),
    .i_n_chunks      (n_chunks),
    .o_busy          (busy),
    .o_done          (done),
    .o_mat_rd_en     (mat_rd_en),
    .o_mat_addr      (mat_addr),
    .i_mat_rdata     (mat_rdata),
    .o_vec_rd_en     (vec_rd_en),
    .o_vec_addr      (vec_addr),
    .i_vec_rdata     (vec_rdata),
    .o_eng_reset     (eng_reset),
    .o_eng_read_now  (eng_read_now),
    .o_eng_first_row (eng_first_row),
    .o_eng_second_row(eng_second_row),
    .o_eng_total     (eng_total),
    .i_eng_finish    (eng_finish),
    .i_eng_result    (eng_result),
    .o_res_valid     (res_valid),
    .i_res_ready     (res_ready),
    .o_res_row       (res_row),
    .o_res_data      (res_data),
    .o_err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine contribution of one package: per-element xor of matrix with half-swapped vector.
  function automatic logic [63:0] pkg_sig(input logic [PW-1:0] m, input logic [PW-1:0] v);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < int'(NU); k++)
      s += m[k*64 +: 64] ^ {v[k*64 +: 32], v[k*64+32 +: 32]};
    return s;
  endfunction

  // Memories with one-cycle read latency.
  logic [PW-1:0] mat_mem [1024];
  logic [PW-1:0] vec_mem [1024];
  always @(posedge clk) begin
    if (mat_rd_en) mat_rdata <= mat_mem[mat_addr];
    if (vec_rd_en) vec_rdata <= vec_mem[vec_addr];
  end

  // Engine model: accumulates packages, raises a sticky finish after a configurable latency.
  int          e_cnt, e_lat, eng_lat_cfg;
  logic [63:0] e_acc;
  bit          eng_never;
  always @(posedge clk) begin
    if (eng_reset) begin
      e_cnt <= 0; e_acc <= '0; e_lat <= 0; eng_finish <= 1'b0; eng_result <= '0;
    end else if (eng_read_now) begin
      e_cnt <= e_cnt + 1;
      e_acc <= e_acc + pkg_sig(eng_first_row, eng_second_row);
      e_lat <= eng_lat_cfg;
    end else if (!eng_never && !eng_finish && e_cnt != 0 && 32'(e_cnt * NU) == eng_total) begin
      if (e_lat == 0) begin
        eng_finish <= 1'b1;
        eng_result <= e_acc;
      end else begin
        e_lat <= e_lat - 1;
      end
    end
  end

  // Result consumer.
  int ready_mode;  // 0: always ready, 1: random, 2: held low
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom % 2);
        default: res_ready = 1'b0;
      endcase
    end
  end

  typedef struct {
    logic [7:0]  row;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  logic [ADDR_W-1:0] mat_log[$], vec_log[$];
  int          rst_pulses, done_cnt, results;
  bit          busy_seen, stall_prev, rn_prev;
  logic [63:0] prev_data;
  logic [7:0]  prev_row;
  logic [PW-1:0] held_f, held_s;

  // Monitor: logs reads, pops scoreboard on each accepted result, checks output stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (mat_rd_en) begin
        mat_log.push_back(mat_addr);
        vec_log.push_back(vec_addr);
      end
      if (eng_reset) rst_pulses++;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", busy, 0);
      end
      if (rn_prev) begin
        chk("pkg_first_held", eng_first_row == held_f, 1);
        chk("pkg_second_held", eng_second_row == held_s, 1);
      end
      rn_prev = eng_read_now;
      held_f  = eng_first_row;
      held_s  = eng_second_row;
      if (res_valid) begin
        chk("no_fetch_in_out", mat_rd_en, 0);
        if (stall_prev) begin
          chk("res_data_stable", res_data, prev_data);
          chk("res_row_stable", res_row, prev_row);
        end
        if (res_ready) begin
          exp_t e;
          results++;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: row=%0d data=%0h with empty scoreboard",
                     res_row, res_data);
          end else begin
            e = sb.pop_front();
            chk("res_row", res_row, e.row);
            chk("res_data", res_data, e.data);
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          prev_data  = res_data;
          prev_row   = res_row;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
      rn_prev    = 1'b0;
    end
  end

  task automatic run_job(input int rows, input int chunks, input int lat,
                         input bit restart, input bit timing, input bit stall);
    int budget;
    int idx;
    mat_log.delete(); vec_log.delete();
    rst_pulses = 0; done_cnt = 0; results = 0;
    eng_lat_cfg = lat;
    for (int r = 0; r < rows; r++) begin
      exp_t e;
      logic [63:0] s;
      s = '0;
      for (int c = 0; c < chunks; c++)
        s += pkg_sig(mat_mem[(r * chunks + c) % 1024], vec_mem[c]);
      e.row  = 8'(r);
      e.data = eng_never ? 64'd0 : s;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; n_rows = 8'(rows); n_chunks = 8'(chunks);
    @(posedge clk); #1;
    start = 1'b0; n_rows = 8'($urandom); n_chunks = 8'($urandom);
    if (timing) begin
      @(negedge clk);
      chk("c1_rowrst", eng_reset, 1);
      chk("c1_busy", busy, 1);
      chk("c1_eng_total", eng_total, 32'(chunks * NU));
      @(negedge clk);
      chk("c2_fetch", mat_rd_en, 1);
      chk("c2_mat_addr", mat_addr, 0);
      @(negedge clk);
      chk("c3_load_no_strobe", eng_read_now, 0);
      @(negedge clk);
      chk("c4_read_now", eng_read_now, 1);
      @(negedge clk);
      chk("c5_hold_no_strobe", eng_read_now, 0);
      @(negedge clk);
      chk("c6_fetch", mat_rd_en, 1);
    end
    if (restart) begin
      repeat (3) @(posedge clk);
      #1; start = 1'b1; n_rows = 8'(rows + 3); n_chunks = 8'd1;
      @(posedge clk); #1; start = 1'b0;
    end
    if (stall) begin
      budget = 0;
      do begin @(negedge clk); budget++; end while (!res_valid && budget < 2000);
      chk("stall_reached_out", res_valid, 1);
      repeat (20) begin
        @(negedge clk);
        chk("stall_valid_held", res_valid, 1);
        chk("stall_no_rowrst", eng_reset, 0);
      end
      ready_mode = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rowrst_after_release", eng_reset, 1);
    end
    budget = 0;
    while (done_cnt == 0 && budget < 20000) begin @(negedge clk); budget++; end
    chk("job_done_in_time", done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("eng_reset_pulses", rst_pulses, rows);
    chk("result_count", results, rows);
    chk("scoreboard_empty", sb.size(), 0);
    chk("eng_total", eng_total, 32'(chunks * NU));
    chk("busy_idle", busy, 0);
    chk("read_count", mat_log.size(), rows * chunks);
    if (mat_log.size() == rows * chunks) begin
      idx = 0;
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < chunks; c++) begin
          chk("mat_addr_seq", mat_log[idx], (r * chunks + c) % 1024);
          chk("vec_addr_seq", vec_log[idx], c);
          idx++;
        end
    end
    sb.delete();
  endtask

  task automatic zero_test(input int rows, input int chunks);
    mat_log.delete(); done_cnt = 0; busy_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; n_rows = 8'(rows); n_chunks = 8'(chunks);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("empty_done_c1", done, 1);
    chk("empty_busy_c1", busy, 0);
    repeat (5) @(negedge clk);
    chk("empty_no_reads", mat_log.size(), 0);
    chk("empty_busy_never", busy_seen, 0);
    chk("empty_done_once", done_cnt, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mat_rd_en"}, mat_rd_en, 0);
    chk({tag, "_vec_rd_en"}, vec_rd_en, 0);
    chk({tag, "_read_now"}, eng_read_now, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mat_addr"}, mat_addr, 0);
    chk({tag, "_vec_addr"}, vec_addr, 0);
    chk({tag, "_res_row"}, res_row, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_first_row_zero"}, |eng_first_row, 0);
    chk({tag, "_second_row_zero"}, |eng_second_row, 0);
    chk({tag, "_eng_total"}, eng_total, 0);
    chk({tag, "_eng_reset"}, eng_reset, 1);
  endtask

  task automatic reset_test();
    int k, budget;
    k = 0; budget = 0; eng_lat_cfg = 1;
    @(posedge clk); #1;
    start = 1'b1; n_rows = 8'd1; n_chunks = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < 3 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (eng_read_now) k++;
    end
    chk("third_issue_seen", k, 3);
    @(posedge clk); #1;  // now in HOLD of chunk 2
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midjob_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < int'(PW / 32); k++) begin
        mat_mem[i][k*32 +: 32] = $urandom;
        vec_mem[i][k*32 +: 32] = $urandom;
      end
    reset = 1'b1; start = 1'b0; n_rows = '0; n_chunks = '0;
    ready_mode = 0; eng_never = 1'b0; eng_lat_cfg = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(2, 3, 3, 1'b0, 1'b1, 1'b0);
    zero_test(5, 0);
    zero_test(0, 4);
    ready_mode = 2;
    run_job(3, 2, 1, 1'b0, 1'b0, 1'b1);
    ready_mode = 0;
    run_job(2, 2, 0, 1'b1, 1'b0, 1'b0);
    reset_test();
    run_job(1, 2, 2, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      ready_mode = 1;
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
              int'($urandom_range(0, 6)), 1'b0, 1'b0, 1'b0);
    end
    ready_mode = 0;
`ifdef DP_SCHED_TIMEOUT_EN
    eng_never = 1'b1;
    run_job(1, 1, 0, 1'b0, 1'b0, 1'b0);
    chk("timeout_err", err, 1);
    eng_never = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", err, 0);
`else
    chk("err_tied_low", err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
